pixel_fb_writer: RTL
====================

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have port clk  input  1  single clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_x  input  8  pixel column from the drawing engine (valid 0..159).
REQ-004 SHALL have port in_y  input  7  pixel row (valid 0..119).
REQ-005 SHALL have port in_colour  input  3  pixel colour.
REQ-006 SHALL have port in_plot  input  1  pixel request qualifier, one pixel per high cycle.
REQ-007 SHALL have port in_ready  output  1  space available; high = !full.
REQ-008 SHALL have port mem_grant  input  1  framebuffer write port available to this block this cycle.
REQ-009 SHALL have port mem_addr  output  15  framebuffer word address.
REQ-010 SHALL have port mem_data  output  3  framebuffer write colour.
REQ-011 SHALL have port mem_we  output  1  framebuffer write strobe, one write per high cycle.
REQ-012 SHALL have port overflow_clr  input  1  synchronous clear of overflow.
REQ-013 SHALL have port overflow  output  1  sticky: a request arrived while full and was dropped.
REQ-014 SHALL have port busy  output  1  high while occupancy != 0 or mem_we high.

Function
REQ-015 SHALL buffer pixels in a 4-entry FIFO of {addr[14:0], colour[2:0]}, tracking occupancy 0..4.
REQ-016 SHALL accept a pixel at a rising edge when in_plot=1, in_ready=1, in_x<160 and in_y<120.
REQ-017 SHALL silently discard in-range-failing requests (in_x>=160 or in_y>=120); no push, no overflow.
REQ-018 SHALL compute addr = in_y*160 + in_x at push using shifts/adds ((y<<7)+(y<<5)+x), 15-bit result, max 19199.
REQ-019 SHALL drop an in-range request arriving with occupancy=4 and set overflow at that edge, even if a pop occurs the same edge.
REQ-020 SHALL pop the head at an edge when occupancy>0 and mem_grant=1.
REQ-021 SHALL register mem_addr, mem_data and mem_we=1 at the pop edge; mem_we is 0 after any edge without pop.
REQ-022 SHALL hold mem_addr/mem_data at last written values when mem_we=0.
REQ-023 SHALL support simultaneous push and pop when occupancy is 1..3; occupancy unchanged.
REQ-024 SHALL give latency: push at edge E into empty FIFO with mem_grant high -> pop at E+1 -> mem_we high for cycle after E+1.
REQ-025 SHALL sustain one pixel per cycle throughput with mem_grant continuously high.
REQ-026 SHALL preserve order: writes leave in acceptance order.
REQ-027 SHALL clear overflow when overflow_clr=1 at an edge; a new overflow event at the same edge wins (stays 1).
REQ-028 SHALL drive in_ready and busy combinationally from registered state only.

Reset
REQ-029 SHALL on rst_n=0 asynchronously clear occupancy, FIFO pointers, mem_we, mem_addr, mem_data, overflow to 0.
REQ-030 SHALL discard buffered pixels on reset mid-operation; no mem_we while rst_n=0.
REQ-031 SHALL present in_ready=1, busy=0 on the first cycle after reset release.

Configuration
REQ-032 SHALL, with PIXEL_CLIP_COUNT_EN defined, add output clip_count[15:0] counting discarded out-of-range requests, saturating at 65535, reset to 0, cleared by overflow_clr.
REQ-033 SHALL, without PIXEL_CLIP_COUNT_EN, omit clip_count port and its logic; all other behaviour identical.

Verification
REQ-034 Reset then push (x=0,y=0,c=5) with mem_grant=1 -> mem_we one cycle, mem_addr=0, mem_data=5, then busy=0.
REQ-035 Push (159,119,c=2) and (1,1,c=7) back-to-back, grant=1 -> addrs 19199 then 161 on consecutive mem_we cycles.
REQ-036 mem_grant=0, push 5 in-range pixels -> in_ready=0 after 4th, 5th dropped, overflow=1; grant=1 -> exactly 4 writes in order.
REQ-037 Push (160,0) and (0,120) -> no write, overflow=0; clip_count=2 when PIXEL_CLIP_COUNT_EN defined.
REQ-038 Assert rst_n=0 with occupancy=3 -> mem_we=0 immediately, occupancy=0, no writes after release.
REQ-039 Feed a full 160x120 raster, one pixel/cycle, grant=1 -> 19200 writes, addresses 0..19199 each once, overflow=0.

Source files
------------

// File: rtl/pixel_fb_writer.sv
// Pixel framebuffer writer: range-checks plot requests, buffers them in a 4-deep FIFO
// and drains one write per granted cycle. Optional clip counter under PIXEL_CLIP_COUNT_EN.
module pixel_fb_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  input  logic        mem_grant,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  input  logic        overflow_clr,
  output logic        overflow,
  output logic        busy
`ifdef PIXEL_CLIP_COUNT_EN
  ,
  output logic [15:0] clip_count
`endif
);

  localparam int DEPTH = 4;

  logic [17:0] fifo_mem [DEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [2:0]  count_next;

  logic        in_range;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic [14:0] y_ext;
  logic [14:0] push_addr;

  // row*160 built as row*128 + row*32 to avoid a multiplier
  assign y_ext     = {8'd0, in_y};
  assign push_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, in_x};

  assign in_range = (in_x < 8'd160) && (in_y < 7'd120);
  assign full     = (count == 3'd4);
  assign push     = in_plot && in_range && !full;
  assign drop     = in_plot && in_range && full;
  assign pop      = (count != 3'd0) && mem_grant;

  assign in_ready = !full;
  assign busy     = (count != 3'd0) || mem_we;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 3'd1;
    end else if (pop && !push) begin
      count_next = count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {push_addr, in_colour};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

  // Write port registers hold their last values while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= 15'd0;
      mem_data <= 3'd0;
    end else begin
      mem_we <= pop;
      if (pop) begin
        mem_addr <= fifo_mem[rd_ptr][17:3];
        mem_data <= fifo_mem[rd_ptr][2:0];
      end
    end
  end

  // A drop at the same edge as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef PIXEL_CLIP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= 16'd0;
    end else if (overflow_clr) begin
      clip_count <= 16'd0;
    end else if (in_plot && !in_range && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule
